// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Fetch sequencer placed between the RAM read port and the program counter.
// It captures one- or two-byte instructions from the registered RAM output
// and generates the PC increment/load strobes. Fetching continues while go
// is high, and the sequencer stops in HALT on HALT_OP.
//
// Ports
//   clk          single clock, shared with PC and RAM
//   reset        synchronous active-high reset
//   go           level request: run continuously while high
//   Q[7:0]       RAM read data, valid in the cycle after the address edge
//   INCR_PC      one-cycle PC increment strobe
//   LOAD_PC      one-cycle PC load strobe
//   ADDR[7:0]    PC load value, 0 unless LOAD_PC is high
//   IR[7:0]      last captured opcode
//   OPERAND[7:0] last captured operand byte
//   instr_valid  one-cycle pulse in DONE
//   instr_count  completed-instruction counter, wraps 255 -> 0
//   halted       high in HALT
//   state[2:0]   encoded state for the debug display
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [7:0] HALT_OP = 8'h7F,
   parameter logic [7:0] JMP_OP  = 8'h80
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic [7:0] Q,
   output logic       INCR_PC,
   output logic       LOAD_PC,
   output logic [7:0] ADDR,
   output logic [7:0] IR,
   output logic [7:0] OPERAND,
   output logic       instr_valid,
   output logic [7:0] instr_count,
   output logic       halted,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      F_WAIT  = 3'd1,
      F_LATCH = 3'd2,
      A_WAIT  = 3'd3,
      A_LATCH = 3'd4,
      DONE    = 3'd5,
      HALT    = 3'd6
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_ir;
   logic [7:0] r_operand;
   logic [7:0] r_count;

   logic       w_incr;
   logic       w_load;
   logic [7:0] w_addr;
   logic       w_valid;
   logic       w_halted;
   logic       w_cap_ir;
   logic       w_cap_op;

   // State register and the captured registers. Reset wins over everything,
   // so an instruction in flight is simply abandoned.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_ir      <= 8'h00;
         r_operand <= 8'h00;
         r_count   <= 8'h00;
      end else begin
         r_state <= w_state_next;
         if (w_cap_ir) begin
            r_ir <= Q;
         end
         if (w_cap_op) begin
            r_operand <= Q;
         end
         if (w_valid) begin
            r_count <= r_count + 8'd1;
         end
      end
   end

   // Next-state and strobe decode. Strobes are purely a function of the
   // current state, so each lasts exactly the one cycle spent in that state
   // and reset drops them on the same edge it forces IDLE.
   always_comb begin
      w_state_next = r_state;
      w_incr       = 1'b0;
      w_load       = 1'b0;
      w_addr       = 8'h00;
      w_valid      = 1'b0;
      w_halted     = 1'b0;
      w_cap_ir     = 1'b0;
      w_cap_op     = 1'b0;
      case (r_state)
         IDLE: begin
            if (go) begin
               w_state_next = F_WAIT;
            end
         end
         F_WAIT: begin
            w_state_next = F_LATCH;
         end
         F_LATCH: begin
            w_cap_ir = 1'b1;
            w_incr   = 1'b1;
            w_state_next = Q[7] ? A_WAIT : DONE;
         end
         A_WAIT: begin
            w_state_next = A_LATCH;
         end
         A_LATCH: begin
            w_cap_op = 1'b1;
            // r_ir already holds the opcode captured in F_LATCH.
            if (r_ir == JMP_OP) begin
               w_load = 1'b1;
               w_addr = Q;
            end else begin
               w_incr = 1'b1;
            end
            w_state_next = DONE;
         end
         DONE: begin
            w_valid = 1'b1;
            if (r_ir == HALT_OP) begin
               w_state_next = HALT;
            end else if (go) begin
               w_state_next = F_WAIT;
            end else begin
               w_state_next = IDLE;
            end
         end
         HALT: begin
            w_halted = 1'b1;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign INCR_PC     = w_incr;
   assign LOAD_PC     = w_load;
   assign ADDR        = w_addr;
   assign IR          = r_ir;
   assign OPERAND     = r_operand;
   assign instr_valid = w_valid;
   assign instr_count = r_count;
   assign halted      = w_halted;
   assign state       = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. Contains a program counter and a RAM with a
// registered address, wired as on the board. Expected values are
// hand-computed from the programs loaded into the RAM.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

   logic       clk;
   logic       reset;
   logic       go;
   logic [7:0] q_reg;
   logic       incr_pc;
   logic       load_pc;
   logic [7:0] addr;
   logic [7:0] ir;
   logic [7:0] operand;
   logic       instr_valid;
   logic [7:0] instr_count;
   logic       halted;
   logic [2:0] state;

   logic [7:0] ram [0:255];
   logic [7:0] pc_reg;

   int n_checks;
   int n_pass;

   int cyc_cnt;
   int incr_cnt;
   int load_cnt;
   int valid_cnt;
   int overlap_cnt;
   int addr_bad_cnt;
   int first_valid_cyc;
   logic [7:0] last_ir;
   logic [7:0] load_addr;
   logic [7:0] ir_log [0:3];

   instr_fetch #(
      .HALT_OP(8'h7F),
      .JMP_OP (8'h80)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .go         (go),
      .Q          (q_reg),
      .INCR_PC    (incr_pc),
      .LOAD_PC    (load_pc),
      .ADDR       (addr),
      .IR         (ir),
      .OPERAND    (operand),
      .instr_valid(instr_valid),
      .instr_count(instr_count),
      .halted     (halted),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program counter and RAM with registered address.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg <= 8'h00;
      end else if (load_pc) begin
         pc_reg <= addr;
      end else if (incr_pc) begin
         pc_reg <= pc_reg + 8'd1;
      end
      q_reg <= ram[pc_reg];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
         $display("check %-16s obs=%0h exp=%0h ok", tag, obs, exp);
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock, then sample the outputs 1 ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_cnt++;
      if (incr_pc) incr_cnt++;
      if (load_pc) begin
         load_cnt++;
         load_addr = addr;
      end
      if (incr_pc && load_pc) overlap_cnt++;
      if (!load_pc && addr != 8'h00) addr_bad_cnt++;
      if (instr_valid) begin
         if (valid_cnt < 4) ir_log[valid_cnt] = ir;
         valid_cnt++;
         last_ir = ir;
         if (valid_cnt == 1) first_valid_cyc = cyc_cnt;
      end
   endtask

   task automatic clear_stats();
      cyc_cnt = 0; incr_cnt = 0; load_cnt = 0; valid_cnt = 0;
      overlap_cnt = 0; addr_bad_cnt = 0; first_valid_cyc = 0;
      last_ir = 8'h00; load_addr = 8'h00;
      for (int i = 0; i < 4; i++) ir_log[i] = 8'h00;
   endtask

   task automatic do_reset();
      go = 1'b0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      clear_stats();
   endtask

   task automatic clear_ram(input logic [7:0] fill);
      for (int i = 0; i < 256; i++) ram[i] = fill;
   endtask

   task automatic run_until_halt(input int bound);
      for (int i = 0; i < bound && !halted; i++) cyc();
      check("halt_reached", {31'd0, halted}, 32'd1);
   endtask

   task automatic run_until_valid(input int n, input int bound);
      for (int i = 0; i < bound && valid_cnt < n; i++) cyc();
      check("valid_reached", valid_cnt, n);
   endtask

   task automatic run_until_state(input logic [2:0] s, input int bound);
      for (int i = 0; i < bound && state != s; i++) cyc();
      check("state_reached", {29'd0, state}, {29'd0, s});
   endtask

   int incr_snap, load_snap, valid_snap;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      go       = 1'b0;
      reset    = 1'b1;
      clear_ram(8'h00);
      clear_stats();

      // ---- reset state and idle behaviour ----
      do_reset();
      check("rst_state",   {29'd0, state}, 32'd0);
      check("rst_ir",      {24'd0, ir}, 32'd0);
      check("rst_operand", {24'd0, operand}, 32'd0);
      check("rst_count",   {24'd0, instr_count}, 32'd0);
      check("rst_addr",    {24'd0, addr}, 32'd0);
      check("rst_strobes", {28'd0, incr_pc, load_pc, instr_valid, halted}, 32'd0);
      for (int i = 0; i < 10; i++) cyc();
      check("idle_state",   {29'd0, state}, 32'd0);
      check("idle_strobes", incr_cnt + load_cnt + valid_cnt, 32'd0);

      // ---- one-byte program: 01 02 7F ----
      clear_ram(8'h00);
      ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h7F;
      do_reset();
      go = 1'b1;
      run_until_halt(60);
      check("p1_latency", first_valid_cyc, 32'd3);
      check("p1_ir0", {24'd0, ir_log[0]}, 32'h01);
      check("p1_ir1", {24'd0, ir_log[1]}, 32'h02);
      check("p1_ir2", {24'd0, ir_log[2]}, 32'h7F);
      check("p1_incr", incr_cnt, 32'd3);
      check("p1_valid", valid_cnt, 32'd3);
      check("p1_pc", {24'd0, pc_reg}, 32'd3);
      check("p1_count", {24'd0, instr_count}, 32'd3);
      check("p1_state", {29'd0, state}, 32'd6);
      incr_snap = incr_cnt; load_snap = load_cnt; valid_snap = valid_cnt;
      for (int i = 0; i < 20; i++) cyc();
      check("p1_quiet", (incr_cnt - incr_snap) + (load_cnt - load_snap) + (valid_cnt - valid_snap), 32'd0);
      check("p1_still_halted", {31'd0, halted}, 32'd1);

      // ---- two-byte non-jump: 85 3C 7F ----
      clear_ram(8'h00);
      ram[0] = 8'h85; ram[1] = 8'h3C; ram[2] = 8'h7F;
      do_reset();
      go = 1'b1;
      run_until_valid(1, 20);
      check("p2_latency", first_valid_cyc, 32'd5);
      check("p2_ir", {24'd0, ir}, 32'h85);
      check("p2_operand", {24'd0, operand}, 32'h3C);
      check("p2_incr", incr_cnt, 32'd2);
      run_until_halt(40);
      check("p2_pc", {24'd0, pc_reg}, 32'd3);
      check("p2_operand_kept", {24'd0, operand}, 32'h3C);

      // ---- jump: 80 10, RAM[16]=7F ----
      clear_ram(8'h00);
      ram[0] = 8'h80; ram[1] = 8'h10; ram[16] = 8'h7F;
      do_reset();
      go = 1'b1;
      run_until_halt(40);
      check("jmp_loads", load_cnt, 32'd1);
      check("jmp_addr", {24'd0, load_addr}, 32'h10);
      check("jmp_overlap", overlap_cnt, 32'd0);
      check("jmp_incr", incr_cnt, 32'd2);
      check("jmp_ir", {24'd0, ir}, 32'h7F);
      check("jmp_pc", {24'd0, pc_reg}, 32'h11);
      check("addr_zero", addr_bad_cnt, 32'd0);

      // ---- drop go in F_WAIT, then reset in F_LATCH ----
      clear_ram(8'h01);
      do_reset();
      go = 1'b1;
      run_until_valid(2, 20);
      run_until_state(3'd1, 5);
      valid_snap = valid_cnt;
      go = 1'b0;
      cyc(); cyc(); cyc();
      check("drop_state", {29'd0, state}, 32'd0);
      check("drop_valid", valid_cnt - valid_snap, 32'd1);
      check("drop_count", {24'd0, instr_count}, 32'd3);
      incr_snap = incr_cnt;
      for (int i = 0; i < 3; i++) cyc();
      check("drop_idle", {29'd0, state}, 32'd0);
      check("drop_no_incr", incr_cnt - incr_snap, 32'd0);
      go = 1'b1;
      run_until_state(3'd2, 5);
      reset = 1'b1;
      cyc();
      check("rstmid_state", {29'd0, state}, 32'd0);
      check("rstmid_count", {24'd0, instr_count}, 32'd0);
      check("rstmid_incr", {31'd0, incr_pc}, 32'd0);
      reset = 1'b0;
      go = 1'b0;

      // ---- 256 one-byte instructions: count and PC wrap ----
      clear_ram(8'h01);
      ram[0] = 8'h02;
      do_reset();
      go = 1'b1;
      run_until_valid(256, 900);
      check("wrap_count_ff", {24'd0, instr_count}, 32'hFF);
      check("wrap_pc", {24'd0, pc_reg}, 32'h00);
      cyc();
      check("wrap_count_00", {24'd0, instr_count}, 32'h00);
      check("wrap_state", {29'd0, state}, 32'd1);
      run_until_valid(257, 10);
      check("wrap_refetch", {24'd0, last_ir}, 32'h02);
      check("wrap_overlap", overlap_cnt, 32'd0);
      go = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch sequencer that sits directly downstream of the RAM's read port and upstream of the program counter's control inputs. It watches the RAM output `Q`, captures one- or two-byte instructions into an instruction register and an operand register, and drives `INCR_PC` and `LOAD_PC` back to the program counter so that fetch runs without manual key presses. It is the first step toward a self-sequencing processor on the board. The captured registers are wired to the seven-segment displays.

## Interface
- `HALT_OP`, default 8'h7F: one-byte opcode that stops the sequencer.
- `JMP_OP`, default 8'h80: two-byte opcode that loads `PC` with its operand.
- `clk`, input, 1: the single clock, shared with the program counter and RAM.
- `reset`, input, 1: **synchronous, active-high** reset, shared with the program counter.
- `go`, input, 1: level input. While high, the block fetches continuously. When low, it stops after the current instruction.
- `Q`, input, 8: RAM read data.
- `INCR_PC`, output, 1: one-cycle increment request to the program counter.
- `LOAD_PC`, output, 1: one-cycle load request to the program counter.
- `ADDR`, output, 8: load value for the program counter. It is valid only while `LOAD_PC`=1.
- `IR`, output, 8: last captured opcode.
- `OPERAND`, output, 8: last captured operand byte.
- `instr_valid`, output, 1: one-cycle pulse when an instruction completes.
- `instr_count`, output, 8: number of completed instructions. Wraps from 255 to 0.
- `halted`, output, 1: high in the HALT state.
- `state`, output, 3: encoded state, for debug display.

## Operation
- Opcode format: `Q[7]`=0 means a one-byte instruction. `Q[7]`=1 means a two-byte instruction, where the next byte is the operand.
- State encodings: IDLE=0, F_WAIT=1, F_LATCH=2, A_WAIT=3, A_LATCH=4, DONE=5, HALT=6.
- IDLE: all strobes are low. Go to F_WAIT when `go`=1.
- F_WAIT: one cycle for the RAM to register the current `PC`. Go to F_LATCH.
- F_LATCH:
  - `IR` <= `Q`, `INCR_PC`=1.
  - If `Q[7]`=0, go to DONE.
  - If `Q[7]`=1, go to A_WAIT. `OPERAND` is unchanged for one-byte instructions.
- A_WAIT: one cycle for the RAM to register `PC`+1. Go to A_LATCH.
- A_LATCH:
  - `OPERAND` <= `Q`.
  - If `IR`==`JMP_OP`: `LOAD_PC`=1 and `ADDR`=`Q`, combinationally from `Q`.
  - Otherwise: `INCR_PC`=1.
  - Go to DONE.
- DONE:
  - `instr_valid`=1, `instr_count` <= `instr_count`+1.
  - If `IR`==`HALT_OP`, go to HALT.
  - Else if `go`=1, go to F_WAIT.
  - Else go to IDLE.
- HALT: `halted`=1, all strobes low. Only `reset` leaves this state; `go` is ignored.
- Strobe rules:
  - `INCR_PC` and `LOAD_PC` are never both high.
  - Each strobe is high for exactly one cycle per assertion.
  - `ADDR` = 8'h00 whenever `LOAD_PC`=0.
- Wrap-around: `PC` wrapping from 8'hFF to 8'h00 is handled by the program counter. The sequencer does not check for it.
  - A two-byte instruction at 8'hFF takes its operand from 8'h00.

## Timing
- Reset, applied on a clock edge with `reset`=1:
  - state becomes IDLE.
  - `IR`, `OPERAND`, `instr_count`, `ADDR` = 0.
  - `INCR_PC`, `LOAD_PC`, `instr_valid`, `halted` = 0.
- Reset mid-instruction aborts the instruction immediately: no strobe is asserted after the reset edge and no partial count is recorded. Reset has priority over `go`.
- RAM model: the address is registered on `clk`, and `Q` is valid during the cycle after the edge that captured it. `PC` updates on the same edge as the strobe's cycle ends.
- Latency:
  - One-byte instruction: 3 cycles (F_WAIT, F_LATCH, DONE).
  - Two-byte instruction: 5 cycles.
  - Continuous run: the next F_WAIT immediately follows DONE.
- `go` is sampled only in IDLE and DONE. Dropping `go` mid-instruction completes the current instruction, then returns to IDLE.
- JMP: `PC`=target is visible in DONE, and the next fetch reads from the target.

## Test plan
- Reset, then check outputs:
  - All outputs read 0 and `state`=0.
  - After 10 cycles with `go`=0, still in IDLE with no strobes.
- RAM[0..2] = 8'h01, 8'h02, 8'h7F, `go`=1:
  - `IR` sequence is 01, 02, 7F.
  - Three `INCR_PC` pulses, three `instr_valid` pulses.
  - `halted`=1 with `PC`=3 and `instr_count`=3, then no further strobes for 20 cycles.
- RAM[0]=8'h85, RAM[1]=8'h3C, RAM[2]=8'h7F, `go`=1:
  - Completes in 5 cycles with `IR`=85, `OPERAND`=3C and two `INCR_PC` pulses.
  - Halts at `PC`=3.
- RAM[0]=8'h80, RAM[1]=8'h10, RAM[16]=8'h7F:
  - `LOAD_PC`=1 with `ADDR`=8'h10 for one cycle, with no `INCR_PC` in that cycle.
  - Next `IR`=7F, halted with `PC`=8'h11.
- Running program of 8'h01 bytes:
  - Drop `go` during A_WAIT-free fetch (F_WAIT); the current instruction finishes, `instr_valid` pulses once, and state returns to IDLE.
  - Assert `reset` during F_LATCH; the next cycle is IDLE with `instr_count`=0 and `INCR_PC`=0.
- 256 one-byte 8'h01 instructions with no halt:
  - `instr_count` wraps from FF to 00.
  - `PC` wraps to 0 and fetch continues from address 0.
